spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Front-panel SPI frame controller: samples the host SPI lines (SCLK, MOSI, SS) in the system clock domain, assembles bytes, decodes a command/address byte followed by one or more data bytes, and issues single-cycle register write strobes to the front-panel register bank. It owns the framing, the bit/byte sequencing and the error detection for the SPI byte receiver path, so downstream logic only sees clean, clock-synchronous writes.

## Interface
- TIMEOUT_CYCLES, 1024: CLK cycles allowed between SCLK rising edges inside a frame before the frame is aborted; only used with the timeout feature compiled in; minimum 16.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- SCLK  in  1  SPI clock, asynchronous to CLK, idle low, mode 0; f_SCLK ≤ f_CLK/4.
- MOSI  in  1  SPI data, MSB first, valid at SCLK rise.
- SS  in  1  slave select, active low, asynchronous.
- WR_EN  out  1  one-cycle write strobe.
- WR_ADDR  out  4  register address, valid while WR_EN is high.
- WR_DATA  out  8  register data, valid while WR_EN is high.
- BUSY  out  1  high while a frame is in progress (state ≠ IDLE).
- FRAME_ERR  out  1  one-cycle pulse on a malformed or aborted frame.

## Operation
- SCLK, MOSI and SS each pass through a 2-flop synchronizer; SCLK rise is detected from the synchronized value (current 1, previous 0), giving one sample-enable cycle per SCLK rise.
- Shift register 8 bits, MSB first; 3-bit bit counter; byte complete on the 8th sample.
- Frame = SS low period. Byte 0 = command: bit 7 = 1 write, bits 6:4 reserved (ignored), bits 3:0 start address. Bytes 1..N = data.
- FSM states:
  - IDLE: bit counter cleared; SS falling (sync high->low) -> CMD.
  - CMD: collect byte 0; bit 7 = 1 -> load address, go DATA; bit 7 = 0 -> SKIP.
  - DATA: each completed byte -> WR_EN pulse with current address and byte, then address increments modulo 16 (15 wraps to 0); stays in DATA for bursts.
  - SKIP: ignore all SCLK edges until SS high -> IDLE.
- Any state, synchronized SS high -> IDLE. If SS rises with bit counter ≠ 0 in CMD or DATA -> FRAME_ERR pulse, partial byte discarded, no write.
- SS rising at exactly a byte boundary (counter = 0) is clean; no error.
- Byte completion and SS rise in the same cycle: the write is issued, then IDLE; no error.
- After reset, FSM in IDLE and a frame starts only on an observed SS falling edge; a reset released mid-frame (SS already low) joins nothing until SS goes high and low again.

## Timing
- Reset values: WR_EN 0, WR_ADDR 0, WR_DATA 0, BUSY 0, FRAME_ERR 0; shift register, counters and address 0; state IDLE.
- Input latency: 2 CLK synchronizer + 1 CLK edge detect.
- WR_EN asserted the CLK cycle after the sample-enable cycle of the 8th bit of a data byte; high exactly 1 cycle. WR_ADDR/WR_DATA registered, held until next write.
- FRAME_ERR high exactly 1 cycle, in the cycle the FSM enters IDLE or SKIP due to the error.
- BUSY rises the cycle after the SS falling edge is detected, falls the cycle after SS high is detected.
- Back-to-back bytes: minimum 8 SCLK periods apart, so WR_EN pulses never overlap.

## Configuration
- SPI_FRAME_TIMEOUT_EN defined: idle counter cleared on every sample-enable, increments each CLK in CMD/DATA; on reaching TIMEOUT_CYCLES -> FRAME_ERR pulse, partial byte discarded, go SKIP (waits for SS high).
- Not defined: no counter; a stalled frame stays in CMD/DATA indefinitely until SS rises; TIMEOUT_CYCLES unused.

## Structure
- Package spi_ctrl_pkg: FSM state enum (IDLE, CMD, DATA, SKIP), CMD_WR_BIT = 7, ADDR_W = 4, DATA_W = 8.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rising/falling edge outputs, instantiated for SCLK and SS; MOSI uses the synchronizer only.

## Test plan
- Write frame 0x83, 0x5A -> one WR_EN pulse, WR_ADDR = 3, WR_DATA = 0x5A, FRAME_ERR stays 0, BUSY falls after SS high.
- Burst 0x8E, 0x11, 0x22, 0x33 -> writes (14, 0x11), (15, 0x22), (0, 0x33); address wraps.
- Command 0x05 followed by 0xFF -> no WR_EN, no FRAME_ERR; next valid frame 0x81, 0xA5 writes (1, 0xA5).
- Frame 0x82 then 5 bits and SS high -> FRAME_ERR one pulse, no write; RST asserted mid-byte with SS held low -> all outputs 0, no write until SS toggles high then low.
- With SPI_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES = 64: send 0x84 then 3 bits and stall SCLK -> FRAME_ERR at 64 cycles after last edge, further bits ignored until SS high; without macro, same stimulus -> no FRAME_ERR until SS high.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// spi_reg_ctrl shared types: frame FSM states and field widths.
package spi_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      SKIP
   } state_t;

   localparam int CMD_WR_BIT = 7;
   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 8;
   localparam int BCNT_W     = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-flop synchronizer for an async SPI line, with rise/fall strobes
// taken from the synchronized value against its one-cycle-delayed copy.
module spi_sync_edge (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [2:0] sh;

   always_ff @(posedge CLK) begin
      if (RST) sh <= '0;
      else     sh <= {sh[1:0], d};
   end

   assign q    = sh[1];
   assign rise = sh[1] & ~sh[2];
   assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: command/address byte then data bytes -> register writes.
// Optional frame stall timeout: define SPI_FRAME_TIMEOUT_EN.
module spi_reg_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SCLK,
   input  logic              MOSI,
   input  logic              SS,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   output logic              BUSY,
   output logic              FRAME_ERR
);

   if (TIMEOUT_CYCLES < 16) begin : g_tmo_chk
      $error("TIMEOUT_CYCLES must be at least 16");
   end

   logic sclk_s, sclk_rise, sclk_fall;
   logic ss_s, ss_rise, ss_fall;
   logic [1:0] mosi_sh;
   logic mosi_s;
   logic unused_edges;

   spi_sync_edge u_sclk (
      .CLK  (CLK),
      .RST  (RST),
      .d    (SCLK),
      .q    (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge u_ss (
      .CLK  (CLK),
      .RST  (RST),
      .d    (SS),
      .q    (ss_s),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   assign unused_edges = &{1'b0, sclk_s, sclk_fall, ss_rise};

   always_ff @(posedge CLK) begin
      if (RST) mosi_sh <= '0;
      else     mosi_sh <= {mosi_sh[0], MOSI};
   end

   assign mosi_s = mosi_sh[1];

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                ferr_q, ferr_d;
   logic [DATA_W-1:0]   byte_nx;
   logic                in_frame;
   logic                byte_done;
   logic                tmo_hit;

   assign byte_nx   = {sh_q[DATA_W-2:0], mosi_s};
   assign in_frame  = (state_q == CMD) || (state_q == DATA);
   assign byte_done = in_frame && sclk_rise && (bcnt_q == '1);

`ifdef SPI_FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] tmo_q;

   // Counts CLK cycles since the last SCLK rise while a byte is open
   always_ff @(posedge CLK) begin
      if (RST || !in_frame || sclk_rise) tmo_q <= '0;
      else                              tmo_q <= tmo_q + 1'b1;
   end

   assign tmo_hit = in_frame && !sclk_rise &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      sh_d      = sh_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ferr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            bcnt_d = '0;
            sh_d   = '0;
            if (ss_fall) state_d = CMD;
         end
         CMD, DATA: begin
            if (sclk_rise) begin
               sh_d   = byte_nx;
               bcnt_d = bcnt_q + 1'b1;
            end
            if (byte_done && state_q == CMD) begin
               if (byte_nx[CMD_WR_BIT]) begin
                  addr_d  = byte_nx[ADDR_W-1:0];
                  state_d = DATA;
               end else begin
                  state_d = SKIP;
               end
            end else if (byte_done) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = byte_nx;
               addr_d    = addr_q + 1'b1;
            end
         end
         SKIP: bcnt_d = '0;
         default: state_d = IDLE;
      endcase

      if (tmo_hit) begin
         state_d = SKIP;
         bcnt_d  = '0;
         ferr_d  = 1'b1;
      end

      // A byte finishing as SS rises still writes; only a partial byte errors
      if (ss_s && state_q != IDLE) begin
         state_d = IDLE;
         bcnt_d  = '0;
         ferr_d  = in_frame && (bcnt_q != '0) && !byte_done;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         bcnt_q    <= '0;
         sh_q      <= '0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         sh_q      <= sh_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ferr_q    <= ferr_d;
      end
   end

   assign WR_EN     = wr_en_q;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = wr_data_q;
   assign BUSY      = (state_q != IDLE);
   assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: writes, bursts, skips, errors, reset.
module tb_spi_reg_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       SCLK;
   logic       MOSI;
   logic       SS;
   logic       WR_EN;
   logic [3:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic       BUSY;
   logic       FRAME_ERR;

   always #5 CLK = ~CLK;

   spi_reg_ctrl #(.TIMEOUT_CYCLES(64)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .SS        (SS),
      .WR_EN     (WR_EN),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .BUSY      (BUSY),
      .FRAME_ERR (FRAME_ERR)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int rise_cyc = 0;

   logic [3:0] log_addr[$];
   logic [7:0] log_data[$];
   int         log_cyc[$];
   int         ferr_n = 0;
   int         ferr_long = 0;
   int         wr_long = 0;
   logic       prev_wr = 1'b0;
   logic       prev_fe = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (WR_EN) begin
         log_addr.push_back(WR_ADDR);
         log_data.push_back(WR_DATA);
         log_cyc.push_back(cyc);
      end
      if (WR_EN && prev_wr) wr_long++;
      if (FRAME_ERR && !prev_fe) ferr_n++;
      if (FRAME_ERR && prev_fe) ferr_long++;
      prev_wr = WR_EN;
      prev_fe = FRAME_ERR;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: time limit reached, want summary first");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic clr_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
      ferr_n = 0;
   endtask

   task automatic spi_bit(input logic b);
      MOSI = b;
      tick(4);
      SCLK = 1'b1;
      rise_cyc = cyc;
      tick(4);
      SCLK = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) spi_bit(v[i]);
   endtask

   task automatic ss_lo();
      SS = 1'b0;
      tick(6);
   endtask

   task automatic ss_hi();
      tick(4);
      SS = 1'b1;
      tick(8);
   endtask

   task automatic test_reset();
      RST = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      tick(3);
      n_chk++;
      if ({WR_EN, WR_ADDR, WR_DATA, BUSY, FRAME_ERR} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got en=%b a=%h d=%h b=%b e=%b want all 0",
                  WR_EN, WR_ADDR, WR_DATA, BUSY, FRAME_ERR);
      end
      RST = 1'b0;
      tick(4);
      n_chk++;
      if (BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy got %b want 0", BUSY);
      end
   endtask

   task automatic test_write();
      clr_log();
      ss_lo();
      spi_byte(8'h83);
      spi_byte(8'h5A);
      n_chk++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL write_busy_mid got %b want 1", BUSY);
      end
      ss_hi();
      n_chk++;
      if (log_addr.size() != 1) begin
         n_fail++;
         $display("FAIL write_count got %0d want 1", log_addr.size());
      end else begin
         n_chk++;
         if (log_addr[0] !== 4'h3 || log_data[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL write_value got (%h,%h) want (3,5a)",
                     log_addr[0], log_data[0]);
         end
         n_chk++;
         if (log_cyc[0] - rise_cyc != 3) begin
            n_fail++;
            $display("FAIL write_latency got %0d want 3",
                     log_cyc[0] - rise_cyc);
         end
      end
      n_chk++;
      if (ferr_n != 0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL write_end got ferr=%0d busy=%b want 0/0",
                  ferr_n, BUSY);
      end
      n_chk++;
      if (WR_ADDR !== 4'h3 || WR_DATA !== 8'h5A) begin
         n_fail++;
         $display("FAIL write_hold got (%h,%h) want (3,5a)", WR_ADDR, WR_DATA);
      end
   endtask

   task automatic test_burst();
      logic [3:0] ea[3] = '{4'd14, 4'd15, 4'd0};
      logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
      clr_log();
      ss_lo();
      spi_byte(8'h8E);
      spi_byte(8'h11);
      spi_byte(8'h22);
      spi_byte(8'h33);
      ss_hi();
      n_chk++;
      if (log_addr.size() != 3) begin
         n_fail++;
         $display("FAIL burst_count got %0d want 3", log_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
               n_fail++;
               $display("FAIL burst_%0d got (%0d,%h) want (%0d,%h)", i,
                        log_addr[i], log_data[i], ea[i], ed[i]);
            end
         end
      end
      n_chk++;
      if (ferr_n != 0) begin
         n_fail++;
         $display("FAIL burst_ferr got %0d want 0", ferr_n);
      end
   endtask

   task automatic test_skip();
      clr_log();
      ss_lo();
      spi_byte(8'h05);
      spi_byte(8'hFF);
      ss_hi();
      n_chk++;
      if (log_addr.size() != 0 || ferr_n != 0) begin
         n_fail++;
         $display("FAIL skip_quiet got wr=%0d ferr=%0d want 0/0",
                  log_addr.size(), ferr_n);
      end
      ss_lo();
      spi_byte(8'h81);
      spi_byte(8'hA5);
      ss_hi();
      n_chk++;
      if (log_addr.size() != 1) begin
         n_fail++;
         $display("FAIL skip_next_count got %0d want 1", log_addr.size());
      end else begin
         n_chk++;
         if (log_addr[0] !== 4'h1 || log_data[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL skip_next_value got (%h,%h) want (1,a5)",
                     log_addr[0], log_data[0]);
         end
      end
   endtask

   task automatic test_same_cycle();
      logic [7:0] v = 8'hC3;
      clr_log();
      ss_lo();
      spi_byte(8'h87);
      for (int i = 7; i >= 1; i--) spi_bit(v[i]);
      MOSI = v[0];
      tick(4);
      SCLK = 1'b1;
      SS = 1'b1;
      tick(4);
      SCLK = 1'b0;
      tick(8);
      n_chk++;
      if (log_addr.size() != 1) begin
         n_fail++;
         $display("FAIL same_cycle_count got %0d want 1", log_addr.size());
      end else begin
         n_chk++;
         if (log_addr[0] !== 4'h7 || log_data[0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL same_cycle_value got (%h,%h) want (7,c3)",
                     log_addr[0], log_data[0]);
         end
      end
      n_chk++;
      if (ferr_n != 0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle_end got ferr=%0d busy=%b want 0/0",
                  ferr_n, BUSY);
      end
   endtask

   task automatic test_partial();
      clr_log();
      ss_lo();
      spi_byte(8'h82);
      for (int i = 0; i < 5; i++) spi_bit(i[0]);
      ss_hi();
      n_chk++;
      if (ferr_n != 1) begin
         n_fail++;
         $display("FAIL partial_ferr got %0d want 1", ferr_n);
      end
      n_chk++;
      if (log_addr.size() != 0) begin
         n_fail++;
         $display("FAIL partial_nowrite got %0d want 0", log_addr.size());
      end
   endtask

   task automatic test_reset_midframe();
      clr_log();
      ss_lo();
      spi_byte(8'h84);
      spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
      RST = 1'b1;
      tick(2);
      n_chk++;
      if ({WR_EN, WR_ADDR, WR_DATA, BUSY, FRAME_ERR} !== 15'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs got en=%b a=%h d=%h b=%b e=%b want all 0",
                  WR_EN, WR_ADDR, WR_DATA, BUSY, FRAME_ERR);
      end
      RST = 1'b0;
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      spi_byte(8'h77);
      n_chk++;
      if (log_addr.size() != 0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_ignored got wr=%0d busy=%b want 0/0",
                  log_addr.size(), BUSY);
      end
      ss_hi();
      n_chk++;
      if (ferr_n != 0) begin
         n_fail++;
         $display("FAIL midrst_ferr got %0d want 0", ferr_n);
      end
      ss_lo();
      spi_byte(8'h84);
      spi_byte(8'h77);
      ss_hi();
      n_chk++;
      if (log_addr.size() != 1) begin
         n_fail++;
         $display("FAIL midrst_rejoin_count got %0d want 1", log_addr.size());
      end else begin
         n_chk++;
         if (log_addr[0] !== 4'h4 || log_data[0] !== 8'h77) begin
            n_fail++;
            $display("FAIL midrst_rejoin_value got (%h,%h) want (4,77)",
                     log_addr[0], log_data[0]);
         end
      end
   endtask

   task automatic test_stall();
      clr_log();
      ss_lo();
      spi_byte(8'h84);
      spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
      tick(150);
`ifdef SPI_FRAME_TIMEOUT_EN
      n_chk++;
      if (ferr_n != 1) begin
         n_fail++;
         $display("FAIL stall_timeout_ferr got %0d want 1", ferr_n);
      end
      for (int i = 0; i < 5; i++) spi_bit(1'b0);
      spi_byte(8'h66);
      n_chk++;
      if (log_addr.size() != 0) begin
         n_fail++;
         $display("FAIL stall_skip_nowrite got %0d want 0", log_addr.size());
      end
`else
      n_chk++;
      if (ferr_n != 0 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_hold got ferr=%0d busy=%b want 0/1",
                  ferr_n, BUSY);
      end
`endif
      ss_hi();
      n_chk++;
      if (ferr_n != 1 || log_addr.size() != 0) begin
         n_fail++;
         $display("FAIL stall_end got ferr=%0d wr=%0d want 1/0",
                  ferr_n, log_addr.size());
      end
   endtask

   task automatic test_pulse_width();
      n_chk++;
      if (wr_long != 0 || ferr_long != 0) begin
         n_fail++;
         $display("FAIL pulse_width got wr_long=%0d ferr_long=%0d want 0/0",
                  wr_long, ferr_long);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_burst();
      test_skip();
      test_same_cycle();
      test_partial();
      test_reset_midframe();
      test_stall();
      test_pulse_width();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
